route_sched: RTL and testbench
==============================

// Module: route_sched
// PURPOSE
//   Destination scheduler in front of cmd_contrl. Takes host bytes from the UART receiver,
//   queues GO destinations and releases them to cmd_contrl one leg at a time: issue, wait
//   for in_transit to rise then fall (arrival), dwell, then issue the next leg.
//   STOP bypasses the queue. Lets the host pre-load a multi-stop route.
// PARAMETERS
//   DEPTH      4      destination queue entries (6-bit IDs); power of 2, >=2
//   DWELL_CYC  25000  idle cycles at each destination before the next GO is issued; >=1
// PORTS
//   clk          in   1   system clock
//   rst          in   1   synchronous, active-high reset
//   host_cmd     in   8   byte from UART rx; [7:6] opcode, [5:0] dest ID
//   host_rdy     in   1   level: host_cmd valid; held until clr_host_rdy
//   clr_host_rdy out  1   1-cycle pulse: host byte consumed
//   cmd          out  8   command byte to cmd_contrl
//   cmd_rdy      out  1   level: cmd valid; held until clr_cmd_rdy
//   clr_cmd_rdy  in   1   from cmd_contrl: cmd consumed
//   in_transit   in   1   from cmd_contrl: robot travelling
//   q_cnt        out  $clog2(DEPTH+1)  queued destinations
//   q_full       out  1   q_cnt == DEPTH
//   drop         out  1   1-cycle pulse: GO discarded, queue full
//   busy         out  1   state != IDLE
// BEHAVIOUR
//   Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
//   Reset: state IDLE, queue empty, all outputs 0 (cmd=8'h00, q_cnt=0).
//   Host intake: accept when host_rdy && !clr_host_rdy (registered; max 1 byte per 2
//     cycles). Every accepted byte pulses clr_host_rdy the next cycle, even if dropped.
//   Opcodes: 01 GO -> enqueue [5:0]; if q_full -> not stored, drop pulses.
//     00 STOP -> flush queue, abort leg, issue 8'h00. 10 CLEAR -> flush queue only; current
//     leg continues. 11 -> consumed, ignored.
//   FSM (enum state_t):
//     IDLE      : queue non-empty -> pop head, cmd={2'b01,ID}, cmd_rdy=1 -> ISSUE
//     ISSUE     : clr_cmd_rdy -> cmd_rdy=0 -> WAIT_START
//     WAIT_START: in_transit==1 -> MOVING
//     MOVING    : in_transit==0 -> load dwell cnt=DWELL_CYC-1 -> DWELL
//     DWELL     : decrement; at 0 -> IDLE (next leg issues the cycle after)
//     STOP_ISSUE: cmd=8'h00, cmd_rdy=1; clr_cmd_rdy -> cmd_rdy=0 -> IDLE
//   STOP from any state: registered next cycle: q_cnt=0, cmd=8'h00, cmd_rdy=1, STOP_ISSUE.
//     In ISSUE, pending GO is overwritten in place; cmd_rdy stays 1 (no low gap).
//   Pop latency: IDLE with non-empty queue -> cmd_rdy high next cycle.
//   Simultaneous: GO enqueue + IDLE pop same cycle -> both occur, q_cnt unchanged; full
//     test uses pre-pop count (drop wins). STOP/CLEAR + pop same cycle -> flush wins,
//     no GO issued. Arrival of an old leg after STOP is ignored (state is not MOVING).
//   Pointers wrap mod DEPTH; q_cnt saturates at DEPTH, never underflows.
//   rst asserted mid-leg: everything back to reset values next edge; no STOP emitted.
// STRUCTURE
//   route_pkg: opcode localparams (OP_STOP=2'b00, OP_GO=2'b01, OP_CLR=2'b10), state_t,
//     STOP_BYTE=8'h00; shared with cmd_contrl.
//   Sub-module dest_fifo (DEPTH x 6, push/pop/flush, count/full/empty, sync reset).
//   FSM, dwell counter and host intake live in route_sched.
// TESTING
//   1 Reset held 2 cycles mid-operation -> all outputs 0, state IDLE, q_cnt=0.
//   2 GO 0x45, GO 0x47 idle -> cmd=0x45 cmd_rdy held until clr; q_cnt=1; in_transit 1->0,
//     DWELL_CYC cycles later cmd=0x47, cmd_rdy=1.
//   3 DEPTH=4, leg in flight, 5 GOs -> q_cnt=4, q_full=1, 5th: drop pulse, clr_host_rdy.
//   4 STOP (0x00) in MOVING, 3 queued -> next cycle q_cnt=0, cmd=0x00, cmd_rdy=1; after
//     clr -> IDLE, no further GO issued.
//   5 CLEAR (0x80) in MOVING, 2 queued -> q_cnt=0, no cmd; after arrival+dwell stay IDLE.
//   6 STOP while in ISSUE with cmd=0x45 -> cmd becomes 0x00, cmd_rdy never drops; 0x45 never
//     acknowledged.

Source files
------------

// File: rtl/route_pkg.sv
// route_pkg
//   Definitions shared between the route scheduler and cmd_contrl: host opcodes,
//   the STOP command byte, the scheduler state type and a helper that builds a
//   GO command byte from a destination ID.
//   No ports (package).

package route_pkg;

    // Host byte layout: [7:6] opcode, [5:0] destination ID
    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GO   = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam logic [7:0] STOP_BYTE = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        MOVING,
        DWELL,
        STOP_ISSUE
    } state_t;

    function automatic logic [7:0] go_byte(input logic [5:0] id);
        return {OP_GO, id};
    endfunction

endpackage

// File: rtl/dest_fifo.sv
// dest_fifo
//   DEPTH x 6-bit destination queue with push, pop and flush.
//   A push while full is discarded (the caller reports the drop); a pop while
//   empty is ignored. Flush empties the queue and overrides push/pop in the same
//   cycle. Head entry is presented combinationally on head_id.
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   push     in   enqueue push_id this cycle
//   push_id  in   6-bit destination ID
//   pop      in   dequeue head this cycle
//   flush    in   empty the queue
//   head_id  out  entry at the head of the queue (valid when !empty)
//   count    out  number of stored entries, 0..DEPTH
//   full     out  count == DEPTH
//   empty    out  count == 0

module dest_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [5:0]                   push_id,
    input  logic                         pop,
    input  logic                         flush,
    output logic [5:0]                   head_id,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [5:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign head_id = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the mod-DEPTH wrap.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/route_sched.sv
// route_sched
//   Destination scheduler in front of cmd_contrl. Host bytes from the UART
//   receiver queue GO destinations; legs are released one at a time: issue the
//   GO, wait for in_transit to rise then fall (arrival), dwell DWELL_CYC cycles,
//   then issue the next leg. STOP bypasses the queue, CLEAR only empties it.
// Ports
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   host_cmd      in   host byte: [7:6] opcode, [5:0] destination ID
//   host_rdy      in   host_cmd valid (level, held until clr_host_rdy)
//   clr_host_rdy  out  1-cycle pulse: host byte consumed
//   cmd           out  command byte to cmd_contrl
//   cmd_rdy       out  cmd valid (level, held until clr_cmd_rdy)
//   clr_cmd_rdy   in   cmd_contrl consumed cmd
//   in_transit    in   robot travelling
//   q_cnt         out  queued destinations
//   q_full        out  q_cnt == DEPTH
//   drop          out  1-cycle pulse: GO discarded because the queue was full
//   busy          out  state != IDLE
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no leg active; pops the queue head as soon as one exists
// ISSUE      | GO byte presented, waiting for cmd_contrl to take it
// WAIT_START | GO taken, waiting for in_transit to rise
// MOVING     | robot travelling, waiting for in_transit to fall
// DWELL      | parked at destination, dwell counter running down
// STOP_ISSUE | STOP byte presented, waiting for cmd_contrl to take it

module route_sched
    import route_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DWELL_CYC = 25000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   host_cmd,
    input  logic                         host_rdy,
    output logic                         clr_host_rdy,
    output logic [7:0]                   cmd,
    output logic                         cmd_rdy,
    input  logic                         clr_cmd_rdy,
    input  logic                         in_transit,
    output logic [$clog2(DEPTH+1)-1:0]   q_cnt,
    output logic                         q_full,
    output logic                         drop,
    output logic                         busy
);

    localparam int DW = $clog2(DWELL_CYC + 1);

    state_t        state;
    logic [DW-1:0] dwell_cnt;

    logic [1:0]    op;
    logic          accept;
    logic          is_go;
    logic          is_stop;
    logic          is_clr;
    logic          flush;
    logic          pop;
    logic [5:0]    head_id;
    logic          q_empty;

    // clr_host_rdy is high for the cycle after an accept, which masks the
    // still-asserted host_rdy so each byte is taken exactly once.
    assign accept  = host_rdy && !clr_host_rdy;
    assign op      = host_cmd[7:6];
    assign is_go   = accept && (op == OP_GO);
    assign is_stop = accept && (op == OP_STOP);
    assign is_clr  = accept && (op == OP_CLR);
    assign flush   = is_stop || is_clr;

    // A flush arriving in the same cycle as a pop wins: nothing is issued.
    assign pop     = (state == IDLE) && !q_empty && !flush;

    dest_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (is_go),
        .push_id (host_cmd[5:0]),
        .pop     (pop),
        .flush   (flush),
        .head_id (head_id),
        .count   (q_cnt),
        .full    (q_full),
        .empty   (q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cmd          <= 8'h00;
            cmd_rdy      <= 1'b0;
            clr_host_rdy <= 1'b0;
            drop         <= 1'b0;
            busy         <= 1'b0;
            dwell_cnt    <= '0;
        end else begin
            clr_host_rdy <= accept;
            // Full test uses the pre-pop count, so a GO racing an IDLE pop
            // into a full queue is still dropped.
            drop         <= is_go && q_full;

            if (is_stop) begin
                // Overwrites a pending GO in place; cmd_rdy stays high.
                cmd     <= STOP_BYTE;
                cmd_rdy <= 1'b1;
                busy    <= 1'b1;
                state   <= STOP_ISSUE;
            end else begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            cmd     <= go_byte(head_id);
                            cmd_rdy <= 1'b1;
                            busy    <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (clr_cmd_rdy) begin
                            cmd_rdy <= 1'b0;
                            state   <= WAIT_START;
                        end
                    end
                    WAIT_START: begin
                        if (in_transit) state <= MOVING;
                    end
                    MOVING: begin
                        if (!in_transit) begin
                            dwell_cnt <= DW'(DWELL_CYC - 1);
                            state     <= DWELL;
                        end
                    end
                    DWELL: begin
                        if (dwell_cnt == '0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            dwell_cnt <= dwell_cnt - DW'(1);
                        end
                    end
                    STOP_ISSUE: begin
                        if (clr_cmd_rdy) begin
                            cmd_rdy <= 1'b0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        cmd_rdy <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_route_sched.sv
module tb_route_sched;

    localparam int DEPTH = 4;
    localparam int DWELL = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    host_cmd;
    logic          host_rdy;
    logic          clr_host_rdy;
    logic [7:0]    cmd;
    logic          cmd_rdy;
    logic          clr_cmd_rdy;
    logic          in_transit;
    logic [CW-1:0] q_cnt;
    logic          q_full;
    logic          drop;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Reference: the queued destinations in arrival order.
    logic [5:0] model_q[$];

    route_sched #(
        .DEPTH     (DEPTH),
        .DWELL_CYC (DWELL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .host_cmd     (host_cmd),
        .host_rdy     (host_rdy),
        .clr_host_rdy (clr_host_rdy),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .in_transit   (in_transit),
        .q_cnt        (q_cnt),
        .q_full       (q_full),
        .drop         (drop),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a byte until the scheduler consumes it (bounded).
    task automatic send_byte(input logic [7:0] b, output logic seen_clr, output logic seen_drop);
        host_cmd  = b;
        host_rdy  = 1'b1;
        seen_clr  = 1'b0;
        seen_drop = 1'b0;
        for (int i = 0; i < 4 && !seen_clr; i++) begin
            tick();
            seen_clr  = clr_host_rdy;
            seen_drop = drop;
        end
        host_rdy = 1'b0;
    endtask

    task automatic wait_cmd_rdy(input int limit, output int n);
        n = 0;
        while (!cmd_rdy && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic ack();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
    endtask

    // Issue one GO from idle, take it and start travelling (leaves robot moving).
    task automatic launch_leg(input logic [5:0] id, output logic [7:0] got);
        logic c, d;
        int   n;
        send_byte({2'b01, id}, c, d);
        wait_cmd_rdy(10, n);
        got = cmd;
        ack();
        in_transit = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        checks++; if (cmd !== 8'h00) begin errors++; $display("FAIL reset_cmd got %h exp 00", cmd); end
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_cmd_rdy got %b exp 0", cmd_rdy); end
        checks++; if (q_cnt !== '0) begin errors++; $display("FAIL reset_q_cnt got %0d exp 0", q_cnt); end
        checks++; if ({q_full, drop, busy, clr_host_rdy} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {q_full, drop, busy, clr_host_rdy}); end
    endtask

    task automatic test_two_legs();
        logic c, d;
        int n;
        logic [5:0] a, b;
        logic [7:0] exp;
        for (int it = 0; it < 3; it++) begin
            a = 6'($urandom);
            b = 6'($urandom);
            model_q.push_back(a);
            send_byte({2'b01, a}, c, d);
            model_q.push_back(b);
            send_byte({2'b01, b}, c, d);
            checks++; if (c !== 1'b1) begin errors++; $display("FAIL go_clr got %b exp 1", c); end
            wait_cmd_rdy(10, n);
            exp = {2'b01, model_q.pop_front()};
            checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL leg1_rdy got %b exp 1", cmd_rdy); end
            checks++; if (cmd !== exp) begin errors++; $display("FAIL leg1_cmd got %h exp %h", cmd, exp); end
            checks++; if (q_cnt !== CW'(model_q.size())) begin errors++; $display("FAIL leg1_q_cnt got %0d exp %0d", q_cnt, model_q.size()); end
            repeat ($urandom_range(1, 5)) begin
                tick();
                checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL leg1_hold got %b exp 1", cmd_rdy); end
            end
            ack();
            checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL leg1_ack got %b exp 0", cmd_rdy); end
            in_transit = 1'b1;
            repeat ($urandom_range(1, 6)) tick();
            in_transit = 1'b0;
            // one edge to see arrival, DWELL cycles parked, one idle cycle, then issue
            n = 0;
            while (!cmd_rdy && n < DWELL + 10) begin
                tick();
                n++;
            end
            exp = {2'b01, model_q.pop_front()};
            checks++; if (n !== DWELL + 2) begin errors++; $display("FAIL dwell_latency got %0d exp %0d", n, DWELL + 2); end
            checks++; if (cmd !== exp) begin errors++; $display("FAIL leg2_cmd got %h exp %h", cmd, exp); end
            checks++; if (q_cnt !== '0) begin errors++; $display("FAIL leg2_q_cnt got %0d exp 0", q_cnt); end
            ack();
            in_transit = 1'b1;
            tick();
            in_transit = 1'b0;
            repeat (DWELL + 2) tick();
            checks++; if ({busy, cmd_rdy} !== 2'b00) begin errors++; $display("FAIL legs_done got %b exp 00", {busy, cmd_rdy}); end
        end
    endtask

    task automatic test_full();
        logic c, d, exp_drop;
        int n;
        logic [5:0] id;
        logic [7:0] got, exp;
        id = 6'($urandom);
        launch_leg(id, got);
        checks++; if (got !== {2'b01, id}) begin errors++; $display("FAIL full_launch got %h exp %h", got, {2'b01, id}); end
        for (int i = 0; i <= DEPTH; i++) begin
            id = 6'($urandom);
            exp_drop = (model_q.size() == DEPTH);
            if (!exp_drop) model_q.push_back(id);
            send_byte({2'b01, id}, c, d);
            checks++; if ({c, d} !== {1'b1, exp_drop}) begin errors++; $display("FAIL full_push%0d got clr/drop %b exp %b", i, {c, d}, {1'b1, exp_drop}); end
        end
        checks++; if (q_cnt !== CW'(DEPTH)) begin errors++; $display("FAIL full_q_cnt got %0d exp %0d", q_cnt, DEPTH); end
        checks++; if (q_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", q_full); end
        tick();
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL drop_pulse got %b exp 0", drop); end
        // arrive, then present a GO exactly on the idle pop cycle: drop wins
        in_transit = 1'b0;
        repeat (DWELL + 1) tick();
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL full_pre_pop got %b exp 0", cmd_rdy); end
        host_cmd = {2'b01, 6'($urandom)};
        host_rdy = 1'b1;
        tick();
        host_rdy = 1'b0;
        exp = {2'b01, model_q.pop_front()};
        checks++; if ({drop, clr_host_rdy, cmd_rdy} !== 3'b111) begin errors++; $display("FAIL race_flags got %b exp 111", {drop, clr_host_rdy, cmd_rdy}); end
        checks++; if (cmd !== exp) begin errors++; $display("FAIL race_cmd got %h exp %h", cmd, exp); end
        checks++; if (q_cnt !== CW'(DEPTH - 1)) begin errors++; $display("FAIL race_q_cnt got %0d exp %0d", q_cnt, DEPTH - 1); end
        for (int k = 0; k < DEPTH - 1; k++) begin
            ack();
            in_transit = 1'b1;
            tick();
            in_transit = 1'b0;
            wait_cmd_rdy(DWELL + 10, n);
            exp = {2'b01, model_q.pop_front()};
            checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL drain%0d_rdy got %b exp 1", k, cmd_rdy); end
            checks++; if (cmd !== exp) begin errors++; $display("FAIL drain%0d_cmd got %h exp %h", k, cmd, exp); end
        end
        ack();
        in_transit = 1'b1;
        tick();
        in_transit = 1'b0;
        repeat (DWELL + 3) tick();
        checks++; if ({busy, cmd_rdy, q_cnt} !== '0) begin errors++; $display("FAIL drain_end got busy/rdy/cnt %b%b%0d exp 000", busy, cmd_rdy, q_cnt); end
    endtask

    task automatic test_stop_moving();
        logic c, d;
        int highs;
        logic [7:0] got;
        launch_leg(6'($urandom), got);
        for (int i = 0; i < 3; i++) begin
            model_q.push_back(6'($urandom));
            send_byte({2'b01, model_q[model_q.size() - 1]}, c, d);
        end
        checks++; if (q_cnt !== CW'(3)) begin errors++; $display("FAIL stop_pre_q_cnt got %0d exp 3", q_cnt); end
        send_byte({2'b00, 6'($urandom)}, c, d);
        model_q.delete();
        checks++; if (q_cnt !== '0) begin errors++; $display("FAIL stop_q_cnt got %0d exp 0", q_cnt); end
        checks++; if ({cmd, cmd_rdy, busy} !== {8'h00, 2'b11}) begin errors++; $display("FAIL stop_cmd got %h/%b%b exp 00/11", cmd, cmd_rdy, busy); end
        in_transit = 1'b0;
        repeat (3) tick();
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL stop_hold got %b exp 1", cmd_rdy); end
        ack();
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL stop_ack got %b exp 0", cmd_rdy); end
        highs = 0;
        repeat (DWELL + 5) begin
            tick();
            if (cmd_rdy) highs++;
        end
        checks++; if (highs !== 0) begin errors++; $display("FAIL stop_no_go got %0d exp 0", highs); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_idle got %b exp 0", busy); end
    endtask

    task automatic test_clear_moving();
        logic c, d;
        int highs;
        logic [7:0] got;
        launch_leg(6'($urandom), got);
        for (int i = 0; i < 2; i++) send_byte({2'b01, 6'($urandom)}, c, d);
        send_byte({2'b10, 6'($urandom)}, c, d);
        checks++; if (q_cnt !== '0) begin errors++; $display("FAIL clr_q_cnt got %0d exp 0", q_cnt); end
        checks++; if ({cmd_rdy, busy} !== 2'b01) begin errors++; $display("FAIL clr_leg got rdy/busy %b exp 01", {cmd_rdy, busy}); end
        in_transit = 1'b0;
        highs = 0;
        repeat (DWELL + 5) begin
            tick();
            if (cmd_rdy) highs++;
        end
        checks++; if (highs !== 0) begin errors++; $display("FAIL clr_no_go got %0d exp 0", highs); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_idle got %b exp 0", busy); end
    endtask

    task automatic test_stop_in_issue();
        logic c, d;
        int n, lows;
        send_byte(8'h45, c, d);
        wait_cmd_rdy(10, n);
        checks++; if ({cmd_rdy, cmd} !== {1'b1, 8'h45}) begin errors++; $display("FAIL issue_cmd got %b/%h exp 1/45", cmd_rdy, cmd); end
        host_cmd = {2'b00, 6'($urandom)};
        host_rdy = 1'b1;
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!cmd_rdy) lows++;
            if (clr_host_rdy) break;
        end
        host_rdy = 1'b0;
        checks++; if (lows !== 0) begin errors++; $display("FAIL issue_gap got %0d exp 0", lows); end
        checks++; if ({cmd_rdy, cmd} !== {1'b1, 8'h00}) begin errors++; $display("FAIL issue_stop got %b/%h exp 1/00", cmd_rdy, cmd); end
        ack();
        repeat (3) tick();
        checks++; if ({busy, cmd_rdy} !== 2'b00) begin errors++; $display("FAIL issue_idle got %b exp 00", {busy, cmd_rdy}); end
    endtask

    task automatic test_nop();
        logic c, d;
        send_byte({2'b11, 6'($urandom)}, c, d);
        checks++; if ({c, d} !== 2'b10) begin errors++; $display("FAIL nop_clr got %b exp 10", {c, d}); end
        repeat (3) tick();
        checks++; if ({q_cnt, cmd_rdy, busy} !== '0) begin errors++; $display("FAIL nop_effect got %0d%b%b exp 000", q_cnt, cmd_rdy, busy); end
    endtask

    task automatic test_reset_mid();
        logic c, d;
        int highs;
        logic [7:0] got;
        launch_leg(6'($urandom), got);
        for (int i = 0; i < 2; i++) send_byte({2'b01, 6'($urandom)}, c, d);
        rst = 1'b1;
        tick();
        tick();
        in_transit = 1'b0;
        test_reset();
        rst = 1'b0;
        highs = 0;
        repeat (DWELL + 5) begin
            tick();
            if (cmd_rdy) highs++;
        end
        checks++; if (highs !== 0) begin errors++; $display("FAIL rst_no_cmd got %0d exp 0", highs); end
    endtask

    initial begin
        rst         = 1'b1;
        host_cmd    = 8'h00;
        host_rdy    = 1'b0;
        clr_cmd_rdy = 1'b0;
        in_transit  = 1'b0;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_two_legs();
        test_full();
        test_stop_moving();
        test_clear_moving();
        test_stop_in_issue();
        test_nop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
